alu_serial: RTL and testbench

//   Parametrised bit-serial ALU; the multi-bit sequential successor of the single-bit ALU cell.

---
 rtl/alu_serial.sv | 111 +++++++++++
 tb/tb_alu_serial.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: bit-serial NOR/XOR/ADD/SUB ALU, one bit per clock, LSB first.
// Operands are captured on start; done pulses for one cycle when result/cout/zero update.
`default_nettype none

module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [1:0]       op_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             b_eff;
    logic             sum_bit;
    logic             carry_nx;
    logic [WIDTH-1:0] res_nx;

    // One slice of the 1-bit ALU cell; b is inverted only for SUB.
    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        b_eff    = bit_b ^ op_r[0];
        carry_nx = (bit_a & b_eff) | (bit_a & carry) | (b_eff & carry);
        case (op_r)
            2'b00:   sum_bit = ~(bit_a | bit_b);
            2'b01:   sum_bit = bit_a ^ bit_b;
            default: sum_bit = bit_a ^ b_eff ^ carry;
        endcase
        res_nx = {sum_bit, res_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_r   <= 2'b00;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nx[WIDTH-1:1];
                    carry  <= carry_nx;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= res_nx;
                        cout   <= op_r[1] & carry_nx;
                        zero   <= (res_nx == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // IDLE and DONE both accept a new request (back-to-back from DONE).
                default: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_r  <= op;
                        carry <= op[0];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed and random checks of alu_serial at WIDTH 8, 2 and 32
// against an arithmetic reference model.
`default_nettype none

module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start2 = 1'b0, start32 = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [1:0]  op = 2'b00;

    logic        busy8, done8, cout8, zero8;
    logic [7:0]  res8;
    logic        busy2, done2, cout2, zero2;
    logic [1:0]  res2;
    logic        busy32, done32, cout32, zero32;
    logic [31:0] res32;

    int n_cmp = 0;
    int n_err = 0;
    int sel = 8;

    logic        s_busy, s_done, s_cout, s_zero;
    logic [63:0] s_res;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a[7:0]), .b(b[7:0]), .op(op),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .zero(zero8));

    alu_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a[1:0]), .b(b[1:0]), .op(op),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .zero(zero2));

    alu_serial #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a[31:0]), .b(b[31:0]), .op(op),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32), .zero(zero32));

    always_comb begin
        s_busy = busy8; s_done = done8; s_cout = cout8; s_zero = zero8; s_res = {56'd0, res8};
        case (sel)
            2: begin
                s_busy = busy2; s_done = done2; s_cout = cout2; s_zero = zero2; s_res = {62'd0, res2};
            end
            32: begin
                s_busy = busy32; s_done = done32; s_cout = cout32; s_zero = zero32; s_res = {32'd0, res32};
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic modulo 2^w.
    function automatic void model(input int w, input logic [1:0] o, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] r, output logic c);
        logic [63:0] m;
        logic [64:0] s;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = x & m;
        y = y & m;
        c = 1'b0;
        s = '0;
        case (o)
            2'b00: r = ~(x | y) & m;
            2'b01: r = (x ^ y) & m;
            2'b10: begin s = {1'b0, x} + {1'b0, y}; r = s[63:0] & m; c = s[w]; end
            default: begin s = {1'b0, x} + {1'b0, (~y) & m} + 65'd1; r = s[63:0] & m; c = s[w]; end
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:  start2 = v;
            32: start32 = v;
            default: start8 = v;
        endcase
    endtask

    task automatic do_op(input int w, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] er;
        logic        ec;
        int          lat;
        sel = w;
        model(w, o, x, y, er, ec);
        @(negedge clk);
        a = x; b = y; op = o;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 2'($urandom);
        chk("busy_after_start", {63'd0, s_busy}, 64'd1);
        lat = 0;
        for (int k = 1; k <= w + 4; k++) begin
            @(posedge clk); #1;
            if (s_done) begin lat = k; break; end
        end
        chk("latency", 64'(lat), 64'(w));
        chk("result", s_res, er);
        chk("cout", {63'd0, s_cout}, {63'd0, ec});
        chk("zero", {63'd0, s_zero}, {63'd0, er == 64'd0});
        chk("busy_in_done", {63'd0, s_busy}, 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, s_done}, 64'd0);
        chk("result_held", s_res, er);
    endtask

    initial begin
        int          nd;
        int          lat;
        logic [63:0] got1;

        #2;
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_result", {56'd0, res8}, 64'd0);
        chk("rst_cout", {63'd0, cout8}, 64'd0);
        chk("rst_zero", {63'd0, zero8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8, 2'b10, 64'hFF, 64'h01);
        chk("t1_res", s_res, 64'h00);
        chk("t1_cout", {63'd0, s_cout}, 64'd1);
        chk("t1_zero", {63'd0, s_zero}, 64'd1);
        do_op(8, 2'b11, 64'h05, 64'h07);
        chk("t2a_res", s_res, 64'hFE);
        chk("t2a_cout", {63'd0, s_cout}, 64'd0);
        do_op(8, 2'b11, 64'h07, 64'h05);
        chk("t2b_res", s_res, 64'h02);
        chk("t2b_cout", {63'd0, s_cout}, 64'd1);
        do_op(8, 2'b00, 64'hF0, 64'h0F);
        chk("t3a_res", s_res, 64'h00);
        chk("t3a_zero", {63'd0, s_zero}, 64'd1);
        do_op(8, 2'b01, 64'hA5, 64'hFF);
        chk("t3b_res", s_res, 64'h5A);
        chk("t3b_zero", {63'd0, s_zero}, 64'd0);

        // start during RUN must be ignored
        sel = 8;
        @(negedge clk);
        a = 64'h10; b = 64'h20; op = 2'b10; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 64'h77; b = 64'h11; op = 2'b11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        nd = 0;
        got1 = '0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done8) begin nd++; got1 = {56'd0, res8}; end
        end
        chk("ignore_one_done", 64'(nd), 64'd1);
        chk("ignore_result", got1, 64'h30);

        // start held through DONE: back-to-back accept
        @(negedge clk);
        a = 64'h3C; b = 64'h0F; op = 2'b10; start8 = 1'b1;
        @(posedge clk); #1;
        a = 64'h20; b = 64'h30; op = 2'b11;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done8) begin lat = k; break; end
        end
        chk("b2b_first_lat", 64'(lat), 64'd8);
        chk("b2b_first_res", {56'd0, res8}, 64'h4B);
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b_accepted", {63'd0, busy8}, 64'd1);
        lat = 0;
        for (int k = 2; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done8) begin lat = k; break; end
        end
        chk("b2b_gap", 64'(lat), 64'd9);
        chk("b2b_second_res", {56'd0, res8}, 64'hF0);
        chk("b2b_second_cout", {63'd0, cout8}, 64'd0);

        // async reset mid-RUN aborts
        @(negedge clk);
        a = 64'hAA; b = 64'h55; op = 2'b10; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy8}, 64'd0);
        chk("abort_result", {56'd0, res8}, 64'd0);
        chk("abort_done", {63'd0, done8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        do_op(8, 2'b10, 64'h12, 64'h34);
        chk("after_abort_res", s_res, 64'h46);

        for (int i = 0; i < 12; i++)
            do_op(8, 2'($urandom), {32'd0, $urandom}, {32'd0, $urandom});
        for (int i = 0; i < 16; i++)
            do_op(2, 2'($urandom), {32'd0, $urandom}, {32'd0, $urandom});
        for (int i = 0; i < 12; i++)
            do_op(32, 2'($urandom), {32'd0, $urandom}, {32'd0, $urandom});
        do_op(32, 2'b10, 64'hFFFF_FFFF, 64'h1);
        do_op(32, 2'b11, 64'h0, 64'h1);
        do_op(2, 2'b11, 64'h2, 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
